// File: rtl/liteeth_sram_fifo_ctrl.sv
// Purpose: 64-bit streaming FIFO built on a 1rw1r 64x1024 SRAM (rw0 writes, r0 reads) with a 3-entry prefetch queue.
// Latency: a word pushed in cycle T is presented on out_valid_out/out_data_out in cycle T+3.
// Backpressure: in_ready_out drops while the SRAM holds DEPTH words; pop side stalls on out_ready_in; flush_in blocks both.
//
// Ports:
//   clk, rst_n_in (sync, active-low), flush_in  - clock, reset, synchronous clear
//   in_valid_in / in_data_in / in_ready_out     - push stream (MAC RX)
//   out_valid_out / out_data_out / out_ready_in - pop stream (DMA reader)
//   level_out                                   - words held: SRAM + read in flight + output queue
//   sram_rw0_*                                  - macro write port
//   sram_r0_*                                   - macro read port (registered, 1-cycle latency)
module liteeth_sram_fifo_ctrl #(
    parameter int DEPTH    = 1024,
    parameter int AW       = 10,
    parameter int DW       = 64,
    parameter int OQ_DEPTH = 3
) (
    input  logic          clk,
    input  logic          rst_n_in,
    input  logic          flush_in,
    input  logic          in_valid_in,
    input  logic [DW-1:0] in_data_in,
    output logic          in_ready_out,
    output logic          out_valid_out,
    output logic [DW-1:0] out_data_out,
    input  logic          out_ready_in,
    output logic [AW:0]   level_out,
    output logic          sram_rw0_ce_out,
    output logic          sram_rw0_we_out,
    output logic [AW-1:0] sram_rw0_addr_out,
    output logic [DW-1:0] sram_rw0_wd_out,
    output logic          sram_r0_ce_out,
    output logic [AW-1:0] sram_r0_addr_out,
    input  logic [DW-1:0] sram_r0_rd_in
);

    localparam logic [AW:0] SRAM_FULL = (AW+1)'(DEPTH);
    localparam logic [2:0]  OQ_MAX    = 3'(OQ_DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   sram_cnt;
    logic          rd_pipe;

    logic [DW-1:0] oq_mem [0:2];
    logic [1:0]    oq_rd_idx;
    logic [1:0]    oq_wr_idx;
    logic [1:0]    oq_cnt;

    logic          push;
    logic          pop;
    logic          issue;
    logic [2:0]    oq_occ;

    function automatic logic [1:0] oq_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Handshakes and read issue. The occupancy test counts the word already
    // in flight so the queue never needs a fourth slot when it lands.
    always_comb begin
        in_ready_out  = (sram_cnt != SRAM_FULL) && !flush_in;
        push          = in_valid_in && in_ready_out;
        out_valid_out = (oq_cnt != 2'd0) && !flush_in;
        pop           = out_valid_out && out_ready_in;
        oq_occ        = {1'b0, oq_cnt} + {2'b00, rd_pipe};
        issue         = (sram_cnt != '0) && (oq_occ < OQ_MAX + {2'b00, pop}) && !flush_in;
    end

    // SRAM port drive; idle ports are held at zero.
    always_comb begin
        sram_rw0_ce_out   = 1'b0;
        sram_rw0_we_out   = 1'b0;
        sram_rw0_addr_out = '0;
        sram_rw0_wd_out   = '0;
        sram_r0_ce_out    = 1'b0;
        sram_r0_addr_out  = '0;
        if (push) begin
            sram_rw0_ce_out   = 1'b1;
            sram_rw0_we_out   = 1'b1;
            sram_rw0_addr_out = wr_ptr;
            sram_rw0_wd_out   = in_data_in;
        end
        if (issue) begin
            sram_r0_ce_out   = 1'b1;
            sram_r0_addr_out = rd_ptr;
        end
    end

    // Data is gated by valid so stale queue contents never leak after a clear.
    always_comb begin
        out_data_out = out_valid_out ? oq_mem[oq_rd_idx] : '0;
        level_out    = sram_cnt + (AW+1)'(rd_pipe) + (AW+1)'(oq_cnt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n_in || flush_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            sram_cnt  <= '0;
            rd_pipe   <= 1'b0;
            oq_rd_idx <= 2'd0;
            oq_wr_idx <= 2'd0;
            oq_cnt    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            sram_cnt <= sram_cnt + (AW+1)'(push) - (AW+1)'(issue);
            rd_pipe  <= issue;
            if (rd_pipe) begin
                oq_wr_idx <= oq_next(oq_wr_idx);
            end
            if (pop) begin
                oq_rd_idx <= oq_next(oq_rd_idx);
            end
            oq_cnt <= oq_cnt + 2'(rd_pipe) - 2'(pop);
        end
    end

    // Read data is captured only on the cycle after an issue; the macro's
    // output is undefined otherwise.
    always_ff @(posedge clk) begin
        if (rst_n_in && !flush_in && rd_pipe) begin
            oq_mem[oq_wr_idx] <= sram_r0_rd_in;
        end
    end

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
module tb_liteeth_sram_fifo_ctrl;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int CAP   = DEPTH + 3;

    logic          clk = 1'b0;
    logic          rst_n_in;
    logic          flush_in;
    logic          in_valid_in;
    logic [DW-1:0] in_data_in;
    logic          in_ready_out;
    logic          out_valid_out;
    logic [DW-1:0] out_data_out;
    logic          out_ready_in;
    logic [AW:0]   level_out;
    logic          sram_rw0_ce_out;
    logic          sram_rw0_we_out;
    logic [AW-1:0] sram_rw0_addr_out;
    logic [DW-1:0] sram_rw0_wd_out;
    logic          sram_r0_ce_out;
    logic [AW-1:0] sram_r0_addr_out;
    logic [DW-1:0] sram_r0_rd_in;

    always #5 clk = ~clk;

    liteeth_sram_fifo_ctrl dut (
        .clk               (clk),
        .rst_n_in          (rst_n_in),
        .flush_in          (flush_in),
        .in_valid_in       (in_valid_in),
        .in_data_in        (in_data_in),
        .in_ready_out      (in_ready_out),
        .out_valid_out     (out_valid_out),
        .out_data_out      (out_data_out),
        .out_ready_in      (out_ready_in),
        .level_out         (level_out),
        .sram_rw0_ce_out   (sram_rw0_ce_out),
        .sram_rw0_we_out   (sram_rw0_we_out),
        .sram_rw0_addr_out (sram_rw0_addr_out),
        .sram_rw0_wd_out   (sram_rw0_wd_out),
        .sram_r0_ce_out    (sram_r0_ce_out),
        .sram_r0_addr_out  (sram_r0_addr_out),
        .sram_r0_rd_in     (sram_r0_rd_in)
    );

    // SRAM macro: registered read; garbage on r0 whenever ce was low.
    logic [DW-1:0] sram_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (sram_rw0_ce_out && sram_rw0_we_out)
            sram_mem[sram_rw0_addr_out] <= sram_rw0_wd_out;
        if (sram_r0_ce_out)
            sram_r0_rd_in <= sram_mem[sram_r0_addr_out];
        else
            sram_r0_rd_in <= {$urandom(), $urandom()};
    end

    // Reference model: word queue, per-word SRAM occupancy, address sequence counts.
    logic [DW-1:0] q[$];
    bit            vld [DEPTH];
    int            wr_n, rd_n;
    int            n_cmp = 0;
    int            n_bad = 0;

    // Per-cycle snapshot taken at the negedge
    logic          s_rdy, s_ovld, s_push, s_pop, s_r0ce;
    logic [AW:0]   s_lvl;
    logic [DW-1:0] s_odat;
    logic [86:0]   s_sram;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        foreach (vld[i]) vld[i] = 1'b0;
        wr_n = 0;
        rd_n = 0;
    endtask

    // One clock: check outputs against the model at the negedge, advance the model at the posedge.
    task automatic cycle();
        logic          push, pop, r0ce;
        logic [AW-1:0] waddr, raddr;
        logic [DW-1:0] wdat;
        @(negedge clk);
        push  = in_valid_in && in_ready_out;
        pop   = out_valid_out && out_ready_in;
        r0ce  = sram_r0_ce_out;
        waddr = sram_rw0_addr_out;
        raddr = sram_r0_addr_out;
        wdat  = in_data_in;
        s_rdy = in_ready_out; s_ovld = out_valid_out; s_push = push; s_pop = pop;
        s_r0ce = r0ce; s_lvl = level_out; s_odat = out_data_out;
        s_sram = {sram_rw0_ce_out, sram_rw0_we_out, sram_rw0_addr_out, sram_rw0_wd_out,
                  sram_r0_ce_out, sram_r0_addr_out};

        chk("level", 128'(level_out), 128'(q.size()));
        if (q.size() == 0) chk("empty_no_valid", 128'(out_valid_out), 128'(0));
        if (q.size() == CAP) chk("full_not_ready", 128'(in_ready_out), 128'(0));
        if (q.size() < DEPTH && !flush_in) chk("room_ready", 128'(in_ready_out), 128'(1));
        if (rst_n_in && flush_in) begin
            chk("flush_ready", 128'(in_ready_out), 128'(0));
            chk("flush_valid", 128'(out_valid_out), 128'(0));
            chk("flush_r0ce", 128'(r0ce), 128'(0));
        end
        if (out_valid_out && q.size() > 0) chk("head_data", 128'(out_data_out), 128'(q[0]));
        if (push) begin
            chk("rw0_ctl", 128'({sram_rw0_ce_out, sram_rw0_we_out}), 128'(2'b11));
            chk("rw0_addr", 128'(waddr), 128'(wr_n % DEPTH));
            chk("rw0_wd", 128'(sram_rw0_wd_out), 128'(wdat));
            chk("rw0_no_overwrite", 128'(vld[waddr]), 128'(0));
        end else begin
            chk("rw0_idle", 128'({sram_rw0_ce_out, sram_rw0_we_out, sram_rw0_addr_out, sram_rw0_wd_out}), 128'(0));
        end
        if (r0ce) begin
            chk("r0_addr", 128'(raddr), 128'(rd_n % DEPTH));
            chk("r0_word_held", 128'(vld[raddr]), 128'(1));
        end else begin
            chk("r0_idle_addr", 128'(raddr), 128'(0));
        end

        @(posedge clk);
        if (!rst_n_in || flush_in) begin
            model_clear();
        end else begin
            if (pop && q.size() > 0) void'(q.pop_front());
            if (push) q.push_back(wdat);
            if (r0ce) begin vld[raddr] = 1'b0; rd_n++; end
            if (push) begin vld[waddr] = 1'b1; wr_n++; end
        end
        #1;
    endtask

    task automatic chk_reset_snapshot(input string tag);
        chk({tag, "_ready"}, 128'(s_rdy), 128'(1));
        chk({tag, "_valid"}, 128'(s_ovld), 128'(0));
        chk({tag, "_data"}, 128'(s_odat), 128'(0));
        chk({tag, "_level"}, 128'(s_lvl), 128'(0));
        chk({tag, "_sram"}, 128'(s_sram), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, sz, sent, recv, got;
        logic [DW-1:0] popped;

        rst_n_in = 1'b0; flush_in = 1'b0; in_valid_in = 1'b0;
        in_data_in = '0; out_ready_in = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n_in = 1'b1;
        cycle();
        chk_reset_snapshot("reset");

        // Single word: visible at T+3, level 1 for T+1..T+3, 0 at T+4
        in_valid_in = 1'b1; in_data_in = 64'hDEAD_BEEF_0000_0001; out_ready_in = 1'b1;
        cycle();
        in_valid_in = 1'b0; in_data_in = 64'h0123_4567_89AB_CDEF;
        cycle(); chk("sw_t1_valid", 128'(s_ovld), 128'(0)); chk("sw_t1_level", 128'(s_lvl), 128'(1));
        cycle(); chk("sw_t2_valid", 128'(s_ovld), 128'(0)); chk("sw_t2_level", 128'(s_lvl), 128'(1));
        cycle(); chk("sw_t3_valid", 128'(s_ovld), 128'(1)); chk("sw_t3_level", 128'(s_lvl), 128'(1));
        chk("sw_t3_data", 128'(s_odat), 128'(64'hDEAD_BEEF_0000_0001));
        cycle(); chk("sw_t4_level", 128'(s_lvl), 128'(0)); chk("sw_t4_valid", 128'(s_ovld), 128'(0));

        // Fill: 1030 attempts, 1027 accepted
        out_ready_in = 1'b0; acc = 0;
        for (int i = 0; i < 1030; i++) begin
            in_valid_in = 1'b1;
            in_data_in  = 64'hF111_0000_0000_0000 | 64'(acc);
            cycle();
            if (s_push) acc++;
        end
        in_valid_in = 1'b0;
        cycle();
        chk("fill_accepted", 128'(acc), 128'(CAP));
        chk("fill_level", 128'(s_lvl), 128'(CAP));
        chk("fill_ready", 128'(s_rdy), 128'(0));

        // Drain: one word per cycle with no gaps, in order
        out_ready_in = 1'b1; got = 0;
        for (int i = 0; i < 1100 && q.size() > 0; i++) begin
            sz = q.size();
            cycle();
            if (sz > 0) chk("drain_no_gap", 128'(s_ovld), 128'(1));
            if (s_pop) begin
                chk("drain_order", 128'(s_odat), 128'(64'hF111_0000_0000_0000 | 64'(got)));
                got++;
            end
        end
        chk("drain_count", 128'(got), 128'(CAP));
        cycle();
        chk("drain_level", 128'(s_lvl), 128'(0));
        chk("drain_valid", 128'(s_ovld), 128'(0));

        // Streaming with random handshakes, several pointer wraps
        sent = 0; recv = 0;
        for (int i = 0; i < 30000 && (sent < 5000 || q.size() > 0); i++) begin
            in_valid_in  = (sent < 5000) && ($urandom_range(0, 3) != 0);
            in_data_in   = 64'h1000_0000_0000_0000 + 64'(sent);
            out_ready_in = ($urandom_range(0, 3) != 0);
            cycle();
            if (s_push) sent++;
            if (s_pop) begin
                chk("stream_seq", 128'(s_odat), 128'(64'h1000_0000_0000_0000 + 64'(recv)));
                recv++;
            end
        end
        in_valid_in = 1'b0; out_ready_in = 1'b0;
        chk("stream_recv", 128'(recv), 128'(5000));
        chk("stream_empty", 128'(q.size()), 128'(0));

        // Flush while a read is in flight
        in_valid_in = 1'b1; in_data_in = 64'hAAAA_AAAA_AAAA_AAAA;
        cycle();
        in_valid_in = 1'b0;
        cycle();
        chk("fl_issue_seen", 128'(s_r0ce), 128'(1));
        flush_in = 1'b1;
        cycle();
        chk("fl_valid_during", 128'(s_ovld), 128'(0));
        chk("fl_ready_during", 128'(s_rdy), 128'(0));
        flush_in = 1'b0;
        cycle();
        chk("fl_level_after", 128'(s_lvl), 128'(0));
        chk("fl_valid_after", 128'(s_ovld), 128'(0));
        repeat (3) cycle();
        chk("fl_no_stale", 128'(s_lvl), 128'(0));
        in_valid_in = 1'b1; in_data_in = 64'h55; out_ready_in = 1'b1;
        cycle();
        in_valid_in = 1'b0;
        got = 0; popped = '0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            cycle();
            if (s_pop) begin got = 1; popped = s_odat; end
        end
        chk("fl_post_popped", 128'(got), 128'(1));
        chk("fl_post_data", 128'(popped), 128'(64'h55));

        // Reset with 500 words held
        out_ready_in = 1'b0;
        for (int i = 0; i < 600 && q.size() < 500; i++) begin
            in_valid_in = 1'b1;
            in_data_in  = {$urandom(), $urandom()};
            cycle();
        end
        in_valid_in = 1'b0;
        cycle();
        chk("rst_pre_level", 128'(s_lvl), 128'(500));
        rst_n_in = 1'b0;
        cycle();
        rst_n_in = 1'b1;
        cycle();
        chk_reset_snapshot("midrst");
        out_ready_in = 1'b1; got = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid_in = 1'b1; in_data_in = 64'hC0DE_0000_0000_0000 + 64'(i);
            cycle();
            if (s_pop) got++;
        end
        in_valid_in = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            cycle();
            if (s_pop) got++;
        end
        chk("midrst_popped", 128'(got), 128'(3));
        chk("midrst_empty", 128'(q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
